// File: rtl/ex_pkg.sv
// rtl/ex_pkg.sv - aluop encodings and divider state type for the execute stage
package ex_pkg;

    localparam logic [7:0] OP_NOP  = 8'h00;
    localparam logic [7:0] OP_AND  = 8'h24;
    localparam logic [7:0] OP_OR   = 8'h25;
    localparam logic [7:0] OP_XOR  = 8'h26;
    localparam logic [7:0] OP_NOR  = 8'h27;
    localparam logic [7:0] OP_SLL  = 8'h7C;
    localparam logic [7:0] OP_SRL  = 8'h02;
    localparam logic [7:0] OP_SRA  = 8'h03;
    localparam logic [7:0] OP_ADD  = 8'h20;
    localparam logic [7:0] OP_ADDU = 8'h21;
    localparam logic [7:0] OP_SUB  = 8'h22;
    localparam logic [7:0] OP_SUBU = 8'h23;
    localparam logic [7:0] OP_SLT  = 8'h2A;
    localparam logic [7:0] OP_SLTU = 8'h2B;
    localparam logic [7:0] OP_DIV  = 8'h1A;
    localparam logic [7:0] OP_DIVU = 8'h1B;

    typedef enum logic [1:0] {
        IDLE,
        RUN,
        FIN
    } div_state_t;

endpackage

// File: rtl/ex_div_iter.sv
// rtl/ex_div_iter.sv - iterative restoring divider, one quotient bit per cycle
module ex_div_iter
    import ex_pkg::*;
#(
    parameter int DATA_W = 32
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              flush,
    input  logic              hold,
    input  logic              start,
    input  logic              is_signed,
    input  logic [DATA_W-1:0] dividend,
    input  logic [DATA_W-1:0] divisor,
    output logic              busy,
    output logic              done,
    output logic [DATA_W-1:0] quotient,
    output logic [DATA_W-1:0] remainder
);

    localparam int CNT_W = $clog2(DATA_W);

    div_state_t        state, state_nx;
    logic [CNT_W-1:0]  cnt;
    logic [DATA_W-1:0] rem_q, quo_q, dvs_q;
    logic              q_neg, r_neg, div0;
    logic              a_neg, b_neg;
    logic [DATA_W:0]   shifted, trial;

    assign a_neg   = is_signed & dividend[DATA_W-1];
    assign b_neg   = is_signed & divisor[DATA_W-1];
    // Partial remainder shifted left with the next dividend bit; trial subtract decides the quotient bit.
    assign shifted = {rem_q, quo_q[DATA_W-1]};
    assign trial   = shifted - {1'b0, dvs_q};

    assign busy = (state != IDLE);
    assign done = (state == FIN) && !hold && !flush;

    // On divide by zero quo_q still holds |dividend|, so re-signing it recovers the original dividend.
    assign quotient  = div0 ? '1 : (q_neg ? -quo_q : quo_q);
    assign remainder = div0 ? (r_neg ? -quo_q : quo_q) : (r_neg ? -rem_q : rem_q);

    // Next-state: zero divisor skips iteration; FIN waits out downstream stall; flush aborts.
    always_comb begin
        state_nx = state;
        case (state)
            IDLE:    if (start) state_nx = (divisor == '0) ? FIN : RUN;
            RUN:     if (cnt == CNT_W'(DATA_W - 1)) state_nx = FIN;
            FIN:     if (!hold) state_nx = IDLE;
            default: state_nx = IDLE;
        endcase
        if (flush) state_nx = IDLE;
    end

    // State register plus operand latch and restoring-step datapath.
    always_ff @(posedge clk) begin
        if (rst) begin
            state <= IDLE;
            cnt   <= '0;
            rem_q <= '0;
            quo_q <= '0;
            dvs_q <= '0;
            q_neg <= 1'b0;
            r_neg <= 1'b0;
            div0  <= 1'b0;
        end else begin
            state <= state_nx;
            case (state)
                IDLE: begin
                    if (start) begin
                        quo_q <= a_neg ? -dividend : dividend;
                        dvs_q <= b_neg ? -divisor : divisor;
                        rem_q <= '0;
                        cnt   <= '0;
                        q_neg <= a_neg ^ b_neg;
                        r_neg <= a_neg;
                        div0  <= (divisor == '0);
                    end
                end
                RUN: begin
                    cnt <= cnt + 1'b1;
                    if (!trial[DATA_W]) begin
                        rem_q <= trial[DATA_W-1:0];
                        quo_q <= {quo_q[DATA_W-2:0], 1'b1};
                    end else begin
                        rem_q <= shifted[DATA_W-1:0];
                        quo_q <= {quo_q[DATA_W-2:0], 1'b0};
                    end
                end
                default: ;
            endcase
        end
    end

endmodule

// File: rtl/ex_unit.sv
// rtl/ex_unit.sv - execute stage: single-cycle ALU, iterative divide, EX/MEM register
module ex_unit
    import ex_pkg::*;
#(
    parameter int DATA_W     = 32,
    parameter int REG_ADDR_W = 5,
    parameter int ALUOP_W    = 8
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  valid_i,
    output logic                  ready_o,
    input  logic [ALUOP_W-1:0]    aluop_i,
    input  logic [DATA_W-1:0]     reg1_i,
    input  logic [DATA_W-1:0]     reg2_i,
    input  logic [REG_ADDR_W-1:0] waddr_i,
    input  logic                  reg_write_i,
    input  logic                  stall_i,
    input  logic                  flush_i,
    output logic                  valid_o,
    output logic [DATA_W-1:0]     ex_wdata_o,
    output logic [REG_ADDR_W-1:0] ex_waddr_o,
    output logic                  ex_write_o,
    output logic [DATA_W-1:0]     ex_hi_o,
    output logic [DATA_W-1:0]     ex_lo_o,
    output logic                  ex_hilo_we_o,
    output logic                  ovf_o,
    output logic                  stall_req_o
);

    localparam int SH_W = $clog2(DATA_W);

    logic              accept, is_div, div_busy, div_done;
    logic [DATA_W-1:0] div_q, div_r, alu_res, sum, diff;
    logic              alu_wr, alu_ovf;
    logic [SH_W-1:0]   shamt;

    assign is_div      = (aluop_i == OP_DIV) || (aluop_i == OP_DIVU);
    assign ready_o     = !div_busy && !stall_i && !rst;
    assign accept      = valid_i && ready_o && !flush_i;
    assign stall_req_o = div_busy;
    assign shamt       = reg1_i[SH_W-1:0];
    assign sum         = reg1_i + reg2_i;
    assign diff        = reg1_i - reg2_i;

    ex_div_iter #(.DATA_W(DATA_W)) u_div (
        .clk       (clk),
        .rst       (rst),
        .flush     (flush_i),
        .hold      (stall_i),
        .start     (accept && is_div),
        .is_signed (aluop_i == OP_DIV),
        .dividend  (reg1_i),
        .divisor   (reg2_i),
        .busy      (div_busy),
        .done      (div_done),
        .quotient  (div_q),
        .remainder (div_r)
    );

    // Single-cycle ALU result; signed overflow on ADD/SUB suppresses the register write.
    always_comb begin
        alu_res = '0;
        alu_wr  = 1'b1;
        alu_ovf = 1'b0;
        case (aluop_i)
            OP_AND:  alu_res = reg1_i & reg2_i;
            OP_OR:   alu_res = reg1_i | reg2_i;
            OP_XOR:  alu_res = reg1_i ^ reg2_i;
            OP_NOR:  alu_res = ~(reg1_i | reg2_i);
            OP_SLL:  alu_res = reg2_i << shamt;
            OP_SRL:  alu_res = reg2_i >> shamt;
            OP_SRA:  alu_res = $signed(reg2_i) >>> shamt;
            OP_ADDU: alu_res = sum;
            OP_SUBU: alu_res = diff;
            OP_ADD: begin
                alu_res = sum;
                alu_ovf = (reg1_i[DATA_W-1] == reg2_i[DATA_W-1]) && (sum[DATA_W-1] != reg1_i[DATA_W-1]);
                alu_wr  = !alu_ovf;
            end
            OP_SUB: begin
                alu_res = diff;
                alu_ovf = (reg1_i[DATA_W-1] != reg2_i[DATA_W-1]) && (diff[DATA_W-1] != reg1_i[DATA_W-1]);
                alu_wr  = !alu_ovf;
            end
            OP_SLT:  alu_res = {{(DATA_W-1){1'b0}}, ($signed(reg1_i) < $signed(reg2_i))};
            OP_SLTU: alu_res = {{(DATA_W-1){1'b0}}, (reg1_i < reg2_i)};
            default: alu_wr = 1'b0;
        endcase
    end

    // EX/MEM register: flush clears, stall holds, divide completion or a new op loads, else bubble out.
    always_ff @(posedge clk) begin
        if (rst) begin
            valid_o      <= 1'b0;
            ex_wdata_o   <= '0;
            ex_waddr_o   <= '0;
            ex_write_o   <= 1'b0;
            ex_hi_o      <= '0;
            ex_lo_o      <= '0;
            ex_hilo_we_o <= 1'b0;
            ovf_o        <= 1'b0;
        end else if (flush_i) begin
            valid_o      <= 1'b0;
            ex_write_o   <= 1'b0;
            ex_hilo_we_o <= 1'b0;
        end else if (!stall_i) begin
            if (div_done) begin
                valid_o      <= 1'b1;
                ex_wdata_o   <= '0;
                ex_write_o   <= 1'b0;
                ex_hi_o      <= div_r;
                ex_lo_o      <= div_q;
                ex_hilo_we_o <= 1'b1;
                ovf_o        <= 1'b0;
            end else if (accept && !is_div) begin
                valid_o      <= 1'b1;
                ex_wdata_o   <= alu_res;
                ex_waddr_o   <= waddr_i;
                ex_write_o   <= alu_wr & reg_write_i;
                ex_hilo_we_o <= 1'b0;
                ovf_o        <= alu_ovf;
            end else begin
                valid_o      <= 1'b0;
                ex_write_o   <= 1'b0;
                ex_hilo_we_o <= 1'b0;
                ovf_o        <= 1'b0;
            end
        end
    end

endmodule

// File: tb/tb_ex_unit.sv
// tb/tb_ex_unit.sv - self-checking bench for ex_unit at DATA_W=32 and DATA_W=16
module tb_ex_unit;
    import ex_pkg::*;

    logic        clk = 1'b0;
    logic        rst;
    logic        valid_i, stall_i, flush_i, reg_write_i;
    logic [7:0]  aluop_i;
    logic [31:0] reg1_i, reg2_i;
    logic [4:0]  waddr_i;
    logic        ready_o, valid_o, ex_write_o, ex_hilo_we_o, ovf_o, stall_req_o;
    logic [31:0] ex_wdata_o, ex_hi_o, ex_lo_o;
    logic [4:0]  ex_waddr_o;

    logic        h_valid_i, h_ready_o, h_valid_o, h_write_o, h_hilo_we_o, h_ovf_o, h_stall_req_o;
    logic [7:0]  h_aluop_i;
    logic [15:0] h_reg1_i, h_reg2_i, h_wdata_o, h_hi_o, h_lo_o;
    logic [4:0]  h_waddr_o;

    int n_cmp = 0;
    int n_err = 0;

    always #5 clk = ~clk;

    ex_unit #(.DATA_W(32), .REG_ADDR_W(5), .ALUOP_W(8)) dut (
        .clk(clk), .rst(rst), .valid_i(valid_i), .ready_o(ready_o), .aluop_i(aluop_i),
        .reg1_i(reg1_i), .reg2_i(reg2_i), .waddr_i(waddr_i), .reg_write_i(reg_write_i),
        .stall_i(stall_i), .flush_i(flush_i), .valid_o(valid_o), .ex_wdata_o(ex_wdata_o),
        .ex_waddr_o(ex_waddr_o), .ex_write_o(ex_write_o), .ex_hi_o(ex_hi_o), .ex_lo_o(ex_lo_o),
        .ex_hilo_we_o(ex_hilo_we_o), .ovf_o(ovf_o), .stall_req_o(stall_req_o)
    );

    ex_unit #(.DATA_W(16), .REG_ADDR_W(5), .ALUOP_W(8)) dut16 (
        .clk(clk), .rst(rst), .valid_i(h_valid_i), .ready_o(h_ready_o), .aluop_i(h_aluop_i),
        .reg1_i(h_reg1_i), .reg2_i(h_reg2_i), .waddr_i(5'd7), .reg_write_i(1'b1),
        .stall_i(1'b0), .flush_i(1'b0), .valid_o(h_valid_o), .ex_wdata_o(h_wdata_o),
        .ex_waddr_o(h_waddr_o), .ex_write_o(h_write_o), .ex_hi_o(h_hi_o), .ex_lo_o(h_lo_o),
        .ex_hilo_we_o(h_hilo_we_o), .ovf_o(h_ovf_o), .stall_req_o(h_stall_req_o)
    );

    typedef struct {
        logic [7:0]  op;
        logic [31:0] a;
        logic [31:0] b;
        logic [31:0] wdata;
        logic        write;
        logic        ovf;
    } vec_t;

    typedef struct {
        logic [31:0] wdata;
        logic        write;
        logic        ovf;
    } alu_exp_t;

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic chk(input string name, input logic [31:0] got, input logic [31:0] exp);
        n_cmp++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s: got %h expected %h", name, got, exp);
        end
    endtask

    // Reference ALU from the arithmetic definition of each op using wide signed integers.
    function automatic alu_exp_t ref_alu(input logic [7:0] op, input logic [31:0] a, input logic [31:0] b);
        alu_exp_t r;
        longint sa, sb, s;
        int amt;
        sa = longint'($signed(a));
        sb = longint'($signed(b));
        amt = int'(a[4:0]);
        r.write = 1'b1;
        r.ovf   = 1'b0;
        r.wdata = '0;
        case (op)
            OP_AND:  r.wdata = a & b;
            OP_OR:   r.wdata = a | b;
            OP_XOR:  r.wdata = a ^ b;
            OP_NOR:  r.wdata = ~(a | b);
            OP_SLL:  r.wdata = b << amt;
            OP_SRL:  r.wdata = b >> amt;
            OP_SRA:  begin s = sb >>> amt; r.wdata = s[31:0]; end
            OP_ADDU: r.wdata = a + b;
            OP_SUBU: r.wdata = a - b;
            OP_ADD, OP_SUB: begin
                s = (op == OP_ADD) ? sa + sb : sa - sb;
                r.wdata = s[31:0];
                r.ovf   = (s > 64'sd2147483647) || (s < -64'sd2147483648);
                r.write = !r.ovf;
            end
            OP_SLT:  r.wdata = (sa < sb) ? 32'd1 : 32'd0;
            OP_SLTU: r.wdata = (a < b) ? 32'd1 : 32'd0;
            default: r.write = 1'b0;
        endcase
        return r;
    endfunction

    // Reference divide: truncating division, zero divisor gives all-ones quotient and the dividend back.
    task automatic ref_div(input logic [7:0] op, input logic [31:0] a, input logic [31:0] b,
                           output logic [31:0] hi, output logic [31:0] lo);
        longint q, r;
        if (b == 0) begin
            lo = '1;
            hi = a;
        end else if (op == OP_DIV) begin
            q  = longint'($signed(a)) / longint'($signed(b));
            r  = longint'($signed(a)) % longint'($signed(b));
            lo = q[31:0];
            hi = r[31:0];
        end else begin
            lo = a / b;
            hi = a % b;
        end
    endtask

    task automatic do_alu(input logic [7:0] op, input logic [31:0] a, input logic [31:0] b, input string tag);
        alu_exp_t e;
        e = ref_alu(op, a, b);
        valid_i = 1'b1; aluop_i = op; reg1_i = a; reg2_i = b; waddr_i = 5'd9;
        tick();
        valid_i = 1'b0;
        chk({tag, " valid"}, {31'b0, valid_o}, 32'd1);
        chk({tag, " wdata"}, ex_wdata_o, e.wdata);
        chk({tag, " write"}, {31'b0, ex_write_o}, {31'b0, e.write});
        chk({tag, " ovf"},   {31'b0, ovf_o},      {31'b0, e.ovf});
    endtask

    task automatic do_div(input logic [7:0] op, input logic [31:0] a, input logic [31:0] b, input string tag);
        logic [31:0] ehi, elo;
        int cnt, rlow;
        ref_div(op, a, b, ehi, elo);
        valid_i = 1'b1; aluop_i = op; reg1_i = a; reg2_i = b; waddr_i = 5'd4;
        tick();
        valid_i = 1'b0;
        cnt = 0;
        rlow = 0;
        while (!valid_o && cnt < 100) begin
            if (!ready_o) rlow++;
            tick();
            cnt++;
        end
        chk({tag, " latency"}, cnt, (b == 0) ? 32'd1 : 32'd33);
        chk({tag, " ready_low"}, rlow, (b == 0) ? 32'd1 : 32'd33);
        chk({tag, " lo"}, ex_lo_o, elo);
        chk({tag, " hi"}, ex_hi_o, ehi);
        chk({tag, " hilo_we"}, {31'b0, ex_hilo_we_o}, 32'd1);
        chk({tag, " write"}, {31'b0, ex_write_o}, 32'd0);
        chk({tag, " ready_after"}, {31'b0, ready_o}, 32'd1);
    endtask

    initial begin
        vec_t tbl[$];
        vec_t tbl16[$];
        logic [7:0]  ops[16];
        logic [31:0] specials[6];
        logic [31:0] ra, rb;
        logic [7:0]  rop;

        tbl.push_back('{OP_OR,   32'h0000FFFF, 32'hFF000000, 32'hFF00FFFF, 1'b1, 1'b0});
        tbl.push_back('{OP_ADD,  32'h7FFFFFFF, 32'h00000001, 32'h80000000, 1'b0, 1'b1});
        tbl.push_back('{OP_ADDU, 32'h7FFFFFFF, 32'h00000001, 32'h80000000, 1'b1, 1'b0});
        tbl.push_back('{OP_SUB,  32'h80000000, 32'h00000001, 32'h7FFFFFFF, 1'b0, 1'b1});
        tbl.push_back('{OP_SUBU, 32'h00000000, 32'h00000001, 32'hFFFFFFFF, 1'b1, 1'b0});
        tbl.push_back('{OP_SRA,  32'd31,       32'h80000000, 32'hFFFFFFFF, 1'b1, 1'b0});
        tbl.push_back('{OP_SRL,  32'd31,       32'h80000000, 32'h00000001, 1'b1, 1'b0});
        tbl.push_back('{OP_SLL,  32'd4,        32'h0000000F, 32'h000000F0, 1'b1, 1'b0});
        tbl.push_back('{OP_SLL,  32'h21,       32'h00000001, 32'h00000002, 1'b1, 1'b0});
        tbl.push_back('{OP_SLTU, 32'd1,        32'hFFFFFFFF, 32'h00000001, 1'b1, 1'b0});
        tbl.push_back('{OP_SLT,  32'hFFFFFFFF, 32'd1,        32'h00000001, 1'b1, 1'b0});
        tbl.push_back('{OP_SLT,  32'd1,        32'hFFFFFFFF, 32'h00000000, 1'b1, 1'b0});
        tbl.push_back('{OP_AND,  32'hF0F0F0F0, 32'hFF00FF00, 32'hF000F000, 1'b1, 1'b0});
        tbl.push_back('{OP_XOR,  32'hF0F0F0F0, 32'hFF00FF00, 32'h0FF00FF0, 1'b1, 1'b0});
        tbl.push_back('{OP_NOR,  32'h0F0F0F0F, 32'hF0F0F0F0, 32'h00000000, 1'b1, 1'b0});
        tbl.push_back('{OP_NOP,  32'd1,        32'd2,        32'h00000000, 1'b0, 1'b0});
        tbl.push_back('{8'hFF,   32'd1,        32'd2,        32'h00000000, 1'b0, 1'b0});
        tbl.push_back('{OP_ADD,  32'd5,        32'hFFFFFFFD, 32'h00000002, 1'b1, 1'b0});

        tbl16.push_back('{OP_SRA,  32'd15,  32'h8000, 32'hFFFF, 1'b1, 1'b0});
        tbl16.push_back('{OP_SLTU, 32'd1,   32'hFFFF, 32'h0001, 1'b1, 1'b0});
        tbl16.push_back('{OP_ADD,  32'h7FFF, 32'h0001, 32'h8000, 1'b0, 1'b1});
        tbl16.push_back('{OP_SLL,  32'h11,  32'h0001, 32'h0002, 1'b1, 1'b0});

        ops = '{OP_NOP, OP_AND, OP_OR, OP_XOR, OP_NOR, OP_SLL, OP_SRL, OP_SRA,
                OP_ADD, OP_ADDU, OP_SUB, OP_SUBU, OP_SLT, OP_SLTU, OP_DIV, OP_DIVU};
        specials = '{32'h0, 32'h1, 32'hFFFFFFFF, 32'h80000000, 32'h7FFFFFFF, 32'h7};

        rst = 1'b1; valid_i = 1'b0; stall_i = 1'b0; flush_i = 1'b0; reg_write_i = 1'b1;
        aluop_i = OP_NOP; reg1_i = '0; reg2_i = '0; waddr_i = '0;
        h_valid_i = 1'b0; h_aluop_i = OP_NOP; h_reg1_i = '0; h_reg2_i = '0;
        tick();
        tick();
        chk("rst ready", {31'b0, ready_o}, 32'd0);
        chk("rst valid", {31'b0, valid_o}, 32'd0);
        chk("rst wdata", ex_wdata_o, 32'd0);
        chk("rst hilo", {ex_hi_o[15:0], ex_lo_o[15:0]}, 32'd0);
        chk("rst flags", {27'b0, ex_write_o, ex_hilo_we_o, ovf_o, stall_req_o, h_valid_o}, 32'd0);
        rst = 1'b0;
        #1;
        chk("post-rst ready", {31'b0, ready_o}, 32'd1);

        // Back-to-back table vectors, one per cycle, each with its own destination.
        for (int i = 0; i < tbl.size(); i++) begin
            valid_i = 1'b1; aluop_i = tbl[i].op; reg1_i = tbl[i].a; reg2_i = tbl[i].b;
            waddr_i = 5'(i + 3);
            tick();
            chk($sformatf("vec%0d valid", i), {31'b0, valid_o}, 32'd1);
            chk($sformatf("vec%0d wdata", i), ex_wdata_o, tbl[i].wdata);
            chk($sformatf("vec%0d write", i), {31'b0, ex_write_o}, {31'b0, tbl[i].write});
            chk($sformatf("vec%0d ovf", i), {31'b0, ovf_o}, {31'b0, tbl[i].ovf});
            chk($sformatf("vec%0d waddr", i), {27'b0, ex_waddr_o}, 32'(i + 3));
            chk($sformatf("vec%0d hilo_we", i), {31'b0, ex_hilo_we_o}, 32'd0);
        end
        valid_i = 1'b0;
        tick();
        chk("bubble drop valid", {31'b0, valid_o}, 32'd0);

        for (int i = 0; i < tbl16.size(); i++) begin
            h_valid_i = 1'b1; h_aluop_i = tbl16[i].op;
            h_reg1_i = tbl16[i].a[15:0]; h_reg2_i = tbl16[i].b[15:0];
            tick();
            chk($sformatf("w16 vec%0d valid", i), {31'b0, h_valid_o}, 32'd1);
            chk($sformatf("w16 vec%0d wdata", i), {16'b0, h_wdata_o}, tbl16[i].wdata);
            chk($sformatf("w16 vec%0d write", i), {31'b0, h_write_o}, {31'b0, tbl16[i].write});
            chk($sformatf("w16 vec%0d ovf", i), {31'b0, h_ovf_o}, {31'b0, tbl16[i].ovf});
        end
        h_valid_i = 1'b0;

        do_div(OP_DIV,  32'hFFFFFFF9, 32'd2,        "div -7/2");
        do_div(OP_DIVU, 32'd7,        32'd0,        "divu 7/0");
        do_div(OP_DIV,  32'h80000000, 32'hFFFFFFFF, "div min/-1");
        do_div(OP_DIV,  32'hFFFFFFF9, 32'd0,        "div -7/0");

        // Output register holds under stall while a new op is presented.
        do_alu(OP_OR, 32'h0000FFFF, 32'hFF000000, "pre-stall");
        stall_i = 1'b1; valid_i = 1'b1; aluop_i = OP_ADDU; reg1_i = 32'd1; reg2_i = 32'd1;
        #1;
        chk("stall ready", {31'b0, ready_o}, 32'd0);
        tick();
        chk("stall hold valid", {31'b0, valid_o}, 32'd1);
        chk("stall hold wdata", ex_wdata_o, 32'hFF00FFFF);
        stall_i = 1'b0; valid_i = 1'b0;
        tick();
        chk("after stall drop", {31'b0, valid_o}, 32'd0);

        // Stall across FIN for three cycles.
        valid_i = 1'b1; aluop_i = OP_DIVU; reg1_i = 32'd100; reg2_i = 32'd7;
        tick();
        valid_i = 1'b0;
        repeat (32) tick();
        stall_i = 1'b1;
        for (int k = 0; k < 3; k++) begin
            tick();
            chk($sformatf("fin stall%0d valid", k), {31'b0, valid_o}, 32'd0);
            chk($sformatf("fin stall%0d req", k), {31'b0, stall_req_o}, 32'd1);
        end
        stall_i = 1'b0;
        tick();
        chk("fin release valid", {31'b0, valid_o}, 32'd1);
        chk("fin release lo", ex_lo_o, 32'd14);
        chk("fin release hi", ex_hi_o, 32'd2);
        chk("fin release req", {31'b0, stall_req_o}, 32'd0);

        // Flush at RUN step 10, with an OR presented in the flush cycle.
        valid_i = 1'b1; aluop_i = OP_DIV; reg1_i = 32'd100; reg2_i = 32'd7;
        tick();
        valid_i = 1'b0;
        repeat (10) tick();
        flush_i = 1'b1; valid_i = 1'b1; aluop_i = OP_OR; reg1_i = 32'h00F0; reg2_i = 32'h0F00;
        tick();
        flush_i = 1'b0;
        chk("flush valid", {31'b0, valid_o}, 32'd0);
        chk("flush hilo_we", {31'b0, ex_hilo_we_o}, 32'd0);
        chk("flush stall_req", {31'b0, stall_req_o}, 32'd0);
        chk("flush ready", {31'b0, ready_o}, 32'd1);
        tick();
        valid_i = 1'b0;
        chk("post-flush or valid", {31'b0, valid_o}, 32'd1);
        chk("post-flush or wdata", ex_wdata_o, 32'h00000FF0);

        // Reset in the middle of a divide produces no result.
        valid_i = 1'b1; aluop_i = OP_DIV; reg1_i = 32'd50; reg2_i = 32'd3;
        tick();
        valid_i = 1'b0;
        repeat (5) tick();
        rst = 1'b1;
        tick();
        chk("rst-mid req", {31'b0, stall_req_o}, 32'd0);
        chk("rst-mid ready", {31'b0, ready_o}, 32'd0);
        rst = 1'b0;
        repeat (40) begin
            tick();
            if (valid_o) break;
        end
        chk("rst-mid no result", {31'b0, valid_o}, 32'd0);

        // Randomized ops against the reference model.
        for (int i = 0; i < 120; i++) begin
            rop = ops[$urandom_range(0, 15)];
            if (i % 11 == 10) rop = 8'h5F;
            ra = ($urandom_range(0, 2) == 0) ? specials[$urandom_range(0, 5)] : 32'($urandom);
            rb = ($urandom_range(0, 2) == 0) ? specials[$urandom_range(0, 5)] : 32'($urandom);
            if (rop == OP_DIV || rop == OP_DIVU) begin
                if (i % 4 == 0) rb = 32'($urandom_range(1, 9));
                do_div(rop, ra, rb, $sformatf("rnd%0d div", i));
            end else begin
                do_alu(rop, ra, rb, $sformatf("rnd%0d op%02h", i, rop));
            end
        end

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule

// File: doc/ex_unit.md
# ex_unit

Parameterised, registered execute stage for the in-order integer pipeline, sitting between ID and MEM. It executes logic, shift, add/sub and compare ops in one cycle, and signed or unsigned divide iteratively over DATA_W cycles. It owns the EX/MEM output register and exposes a valid/ready issue handshake plus a stall request toward the pipeline controller.

## Interface
- DATA_W, 32: operand and result width; must be a power of 2, at least 8.
- REG_ADDR_W, 5: destination register address width.
- ALUOP_W, 8: aluop field width.
- clk  in  1  clock; all state updates on the rising edge.
- rst  in  1  reset, synchronous, active-high.
- valid_i  in  1  ID presents an op.
- ready_o  out  1  EX accepts an op this cycle.
- aluop_i  in  ALUOP_W  operation code from ex_pkg.
- reg1_i, reg2_i  in  DATA_W  source operands.
- waddr_i  in  REG_ADDR_W  destination register.
- reg_write_i  in  1  op writes the GPR file.
- stall_i  in  1  downstream stall; hold the output register.
- flush_i  in  1  discard the in-flight op and the output register.
- valid_o  out  1  output register holds a result.
- ex_wdata_o  out  DATA_W  GPR write data.
- ex_waddr_o  out  REG_ADDR_W  GPR write address.
- ex_write_o  out  1  GPR write enable.
- ex_hi_o, ex_lo_o  out  DATA_W  divide remainder and quotient.
- ex_hilo_we_o  out  1  HI/LO write enable.
- ovf_o  out  1  signed overflow on ADD or SUB.
- stall_req_o  out  1  divider busy; request the front end to hold.

## Operation
- Ops: AND, OR, XOR, NOR; SLL, SRL, SRA; ADD, ADDU, SUB, SUBU; SLT, SLTU; DIV, DIVU; NOP.
- Shifts: the value is reg2_i and the amount is reg1_i[$clog2(DATA_W)-1:0].
- ADDU/SUBU wrap modulo 2^DATA_W.
- ADD/SUB with signed overflow: ovf_o=1, ex_write_o=0, wdata is the wrapped sum.
- SLT and SLTU produce a zero-extended 0 or 1.
- Unknown aluop or NOP: wdata=0, write=0, hilo_we=0, but valid_o=1 (bubble).
- Divide FSM states:
  - IDLE: on accept of DIV/DIVU, latch |operands| and the quotient/remainder signs, clear the counter, go to RUN.
  - RUN: one restoring step per cycle. After DATA_W steps, go to FIN.
  - FIN: apply signs; the quotient sign is the XOR of the operand signs and the remainder takes the dividend sign. Load the output register when !stall_i, then go to IDLE.
- Divide by zero: skip RUN and go straight to FIN; quotient = all ones, remainder = dividend.
- DIV MIN/-1: quotient = MIN, remainder = 0. This falls out of the unsigned path; no special case.
- DIV results drive ex_hi_o/ex_lo_o with ex_hilo_we_o=1; ex_write_o=0 regardless of reg_write_i.
- ready_o = (state==IDLE) && !stall_i && !rst.
- stall_req_o = (state != IDLE).
- stall_i: the output register holds. The divider keeps iterating but waits in FIN.
- flush_i:
  - clears valid_o, ex_write_o and ex_hilo_we_o, and returns the FSM to IDLE;
  - an op presented in the same cycle is not accepted;
  - flush has priority over stall_i; rst has priority over everything.

## Timing
- Reset values: valid_o=0; all data, address, write, hilo_we and ovf outputs are 0; state=IDLE; ready_o=0 during rst; stall_req_o=0.
- Single-cycle ops: accepted at edge N, result visible after edge N (cycle N+1). Back-to-back issue sustains 1 op per cycle.
- Divide: accepted at edge N; RUN at edges N+1..N+DATA_W; FIN loads the output at edge N+DATA_W+1. Latency is DATA_W+1 cycles with no stall.
- Divide by zero: the output loads at edge N+1.
- valid_o with no new accept: drops to 0 at the next non-stalled edge.
- Reset mid-divide: the FSM returns to IDLE on the next edge and no result is produced.

## Structure
- Package ex_pkg holds:
  - aluop localparams: NOP=8'h00, AND=8'h24, OR=8'h25, XOR=8'h26, NOR=8'h27, SLL=8'h7C, SRL=8'h02, SRA=8'h03, ADD=8'h20, ADDU=8'h21, SUB=8'h22, SUBU=8'h23, SLT=8'h2A, SLTU=8'h2B, DIV=8'h1A, DIVU=8'h1B;
  - the divider state enum (IDLE, RUN, FIN).
- Sub-module ex_div_iter holds the iterative divider: start/busy/done handshake, DATA_W parameter, sign handling inside.
- ex_unit holds the single-cycle ALU, the issue logic and the output register.

## Test plan
- OR 0x0000FFFF | 0xFF000000 to r3 -> one cycle later: valid_o=1, wdata=0xFF00FFFF, waddr=3, write=1.
- ADD 0x7FFFFFFF + 1 -> ovf_o=1, ex_write_o=0. ADDU with the same operands -> wdata=0x80000000, write=1.
- DIV -7 / 2 -> ready_o low for 33 cycles; then lo=0xFFFFFFFD, hi=0xFFFFFFFF, hilo_we=1. DIVU 7/0 -> after 1 cycle: lo=0xFFFFFFFF, hi=7.
- DIV 0x80000000 / 0xFFFFFFFF -> lo=0x80000000, hi=0.
- Stall interaction: stall_i high during FIN for 3 cycles -> output held, result appears on the first cycle after stall_i falls. flush_i at RUN step 10 -> FSM returns to IDLE, valid_o=0, next OR accepted the following cycle.
- Run the SRA 0x80000000 >> 31 case (-> 0xFFFFFFFF) and the SLTU 1 < 0xFFFFFFFF case (-> 1) at DATA_W=16 and DATA_W=32.
